pool_a2_cu: RTL and testbench
=============================

POOL_A2_CU -- requirements
Module: pool_a2_cu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the signed two's-complement pixel width.
REQ-002 SHALL have parameter IFM_SIZE, default 10, meaning the input map side (the upstream conv output side).
REQ-003 SHALL have parameter IFM_DEPTH, default 2, meaning the number of input maps; there is one map per upstream filter.
REQ-004 SHALL derive OFM_SIZE = IFM_SIZE/2 (floor), ADDR_IN = $clog2(IFM_DEPTH*IFM_SIZE*IFM_SIZE) and ADDR_OUT = $clog2(IFM_DEPTH*OFM_SIZE*OFM_SIZE).
REQ-005 SHALL have these ports, clock and reset first:
 clk  in  1  clock; reset reset, asynchronous, active-high; clock clk.
 reset  in  1  asynchronous active-high reset.
 start_from_previous  in  1  upstream buffer full, start pooling.
 end_from_next  in  1  downstream is free to accept a new buffer.
 ifm_data_in  in  DATA_WIDTH  read data, valid 1 cycle after ifm_enable_read.
 end_to_previous  out  1  block idle, upstream buffer may be overwritten.
 ifm_sel_previous  out  1  ping-pong half being read.
 ifm_enable_read  out  1  input memory read strobe.
 ifm_address_read  out  ADDR_IN  input read address.
 ofm_enable_write  out  1  output write strobe.
 ofm_address_write  out  ADDR_OUT  output write address.
 ofm_data_out  out  DATA_WIDTH  pooled value.
 ofm_sel_next  out  1  ping-pong half being written.
 start_to_next  out  1  one-cycle pulse, output buffer complete.
 busy  out  1  high in every state except IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, RUN, DRAIN and WAIT_NEXT.
REQ-007 SHALL transition IDLE -> RUN on start_from_previous, and SHALL toggle ifm_sel_previous on that same edge; start_from_previous SHALL be ignored in all other states.
REQ-008 SHALL, in RUN, assert ifm_enable_read every cycle, issuing for each window the addresses base, base+1, base+IFM_SIZE and base+IFM_SIZE+1 in that order.
REQ-009 SHALL compute base = d*IFM_SIZE^2 + 2r*IFM_SIZE + 2c, with the window order c fastest, then r, then d.
REQ-010 SHALL, for odd IFM_SIZE, never read the last row or column.
REQ-011 SHALL, after the final read (4*IFM_DEPTH*OFM_SIZE^2 reads), transition RUN -> DRAIN; DRAIN SHALL last 1 cycle and then go to WAIT_NEXT.
REQ-012 SHALL pipeline returning data by using a 1-cycle delayed copy of the window phase: phase 0 loads the accumulator, phases 1-2 update it, and phase 3 asserts ofm_enable_write with ofm_data_out = reduce(acc, ifm_data_in).
REQ-013 SHALL make the latency from the first read of a window to its write exactly 4 cycles.
REQ-014 SHALL start ofm_address_write at 0 for each buffer and increment it after each write; the final write SHALL occur in DRAIN.
REQ-015 SHALL define reduce as signed maximum; on ties either operand is acceptable because the values are equal.
REQ-016 SHALL, in WAIT_NEXT with end_from_next high, set registered start_to_next high for exactly 1 cycle, toggle ofm_sel_next and go to IDLE; otherwise it SHALL remain in WAIT_NEXT.
REQ-017 SHALL assert end_to_previous only in IDLE.
REQ-018 SHALL produce the first start_to_next 203 cycles after start acceptance with default parameters when end_from_next is held high.

Reset
REQ-019 SHALL, on reset (including mid-operation), asynchronously force state IDLE and clear all counters, the accumulator, ifm_sel_previous, ofm_sel_next, all strobes, start_to_next, busy and addresses to 0; end_to_previous SHALL be 1.
REQ-020 SHALL NOT emit any write or start_to_next pulse for a buffer interrupted by reset.

Configuration
REQ-021 SHALL, with macro POOL_A2_AVG_EN defined, define reduce as average: a DATA_WIDTH+2-bit sign-extended sum of 4 values, arithmetically shifted right by 2 (floor).
REQ-022 SHALL, without POOL_A2_AVG_EN, use signed max (REQ-015); timing and interface SHALL be identical in both builds.

Verification
REQ-023 SHALL be verified with input memory value = address (defaults) and start pulsed at cycle T: reads at T+1..T+200; first write at T+5 has address 0 and value 11; the last write has address 49 and value 199.
REQ-024 SHALL be verified with a window of -5, -1, -7, -3 in the max build: written value -1; a window of all 0x80000000 gives 0x80000000.
REQ-025 SHALL be verified in the POOL_A2_AVG_EN build: window 1, 2, 3, 6 gives 3; window -1, -2, -3, -4 gives -3; window 0x7FFFFFFF x4 gives 0x7FFFFFFF with no overflow.
REQ-026 SHALL be verified with end_from_next held low for 20 cycles after DRAIN: the block stays in WAIT_NEXT with busy=1 and end_to_previous=0; end_from_next rising then gives a single start_to_next pulse, ofm_sel_next toggles and end_to_previous returns to 1.
REQ-027 SHALL be verified with start_from_previous pulsed during RUN: no restart, and ifm_sel_previous does not change; a second start after IDLE toggles ifm_sel_previous back to 0.
REQ-028 SHALL be verified with reset asserted at T+100: all outputs reach reset values immediately, there is no start_to_next, and a new start after release rereads from address 0.

Source files
------------

// File: rtl/pool_a2_cu.sv
// 2x2 stride-2 pooling controller over ping-pong maps (signed max; average when POOL_A2_AVG_EN is defined).
// Latency: write 4 cycles after a window's first read; holds finished buffer in WAIT_NEXT until end_from_next.
module pool_a2_cu #(
    parameter int DATA_WIDTH = 32,
    parameter int IFM_SIZE   = 10,
    parameter int IFM_DEPTH  = 2,
    localparam int OFM_SIZE  = IFM_SIZE / 2,
    localparam int ADDR_IN   = $clog2(IFM_DEPTH * IFM_SIZE * IFM_SIZE),
    localparam int ADDR_OUT  = $clog2(IFM_DEPTH * OFM_SIZE * OFM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_from_previous,
    input  logic                  end_from_next,
    input  logic [DATA_WIDTH-1:0] ifm_data_in,
    output logic                  end_to_previous,
    output logic                  ifm_sel_previous,
    output logic                  ifm_enable_read,
    output logic [ADDR_IN-1:0]    ifm_address_read,
    output logic                  ofm_enable_write,
    output logic [ADDR_OUT-1:0]   ofm_address_write,
    output logic [DATA_WIDTH-1:0] ofm_data_out,
    output logic                  ofm_sel_next,
    output logic                  start_to_next,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, WAIT_NEXT} state_t;

    localparam int CW = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam int DW = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(OFM_SIZE - 1);
    localparam logic [DW-1:0] D_LAST = DW'(IFM_DEPTH - 1);
    // Base jumps: next column, wrap to next row pair, wrap to next map (odd edge row/col skipped).
    localparam logic [ADDR_IN-1:0] STEP_C  = ADDR_IN'(2);
    localparam logic [ADDR_IN-1:0] STEP_R  = ADDR_IN'(2 * IFM_SIZE - 2 * (OFM_SIZE - 1));
    localparam logic [ADDR_IN-1:0] STEP_D  = ADDR_IN'(IFM_SIZE * IFM_SIZE - 2 * (OFM_SIZE - 1) * IFM_SIZE - 2 * (OFM_SIZE - 1));
    localparam logic [ADDR_IN-1:0] ROW_OFS = ADDR_IN'(IFM_SIZE);

`ifdef POOL_A2_AVG_EN
    localparam int ACC_W = DATA_WIDTH + 2;
`else
    localparam int ACC_W = DATA_WIDTH;
`endif

    state_t              state;
    logic [1:0]          phase;
    logic [1:0]          phase_d;
    logic                rd_vld_d;
    logic [CW-1:0]       col;
    logic [CW-1:0]       row;
    logic [DW-1:0]       dep;
    logic [ADDR_IN-1:0]  base;
    logic                last_rd;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    ext;
    logic [ACC_W-1:0]    acc_upd;
    logic [DATA_WIDTH-1:0] red;

    assign last_rd = (phase == 2'd3) && (col == C_LAST) && (row == C_LAST) && (dep == D_LAST);
    assign ifm_address_read = ifm_enable_read
        ? base + (phase[1] ? ROW_OFS : '0) + {{(ADDR_IN-1){1'b0}}, phase[0]}
        : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            end_to_previous  <= 1'b1;
            ifm_enable_read  <= 1'b0;
            ifm_sel_previous <= 1'b0;
            ofm_sel_next     <= 1'b0;
            start_to_next    <= 1'b0;
            phase            <= 2'd0;
            col              <= '0;
            row              <= '0;
            dep              <= '0;
            base             <= '0;
        end else begin
            start_to_next <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_from_previous) begin
                        state            <= RUN;
                        busy             <= 1'b1;
                        end_to_previous  <= 1'b0;
                        ifm_enable_read  <= 1'b1;
                        ifm_sel_previous <= ~ifm_sel_previous;
                        phase            <= 2'd0;
                        col              <= '0;
                        row              <= '0;
                        dep              <= '0;
                        base             <= '0;
                    end
                end
                RUN: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd3) begin
                        if (last_rd) begin
                            state           <= DRAIN;
                            ifm_enable_read <= 1'b0;
                            col             <= '0;
                            row             <= '0;
                            dep             <= '0;
                            base            <= '0;
                        end else if (col != C_LAST) begin
                            col  <= col + CW'(1);
                            base <= base + STEP_C;
                        end else if (row != C_LAST) begin
                            col  <= '0;
                            row  <= row + CW'(1);
                            base <= base + STEP_R;
                        end else begin
                            col  <= '0;
                            row  <= '0;
                            dep  <= dep + DW'(1);
                            base <= base + STEP_D;
                        end
                    end
                end
                DRAIN: state <= WAIT_NEXT;
                WAIT_NEXT: begin
                    if (end_from_next) begin
                        state           <= IDLE;
                        busy            <= 1'b0;
                        end_to_previous <= 1'b1;
                        start_to_next   <= 1'b1;
                        ofm_sel_next    <= ~ofm_sel_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reduction of the running accumulator with the word returning this cycle.
    always_comb begin
`ifdef POOL_A2_AVG_EN
        ext     = {{2{ifm_data_in[DATA_WIDTH-1]}}, ifm_data_in};
        acc_upd = acc + ext;
        red     = acc_upd[DATA_WIDTH+1:2];
`else
        ext     = ifm_data_in;
        acc_upd = ($signed(ifm_data_in) > $signed(acc)) ? ifm_data_in : acc;
        red     = acc_upd;
`endif
    end

    assign ofm_enable_write = rd_vld_d && (phase_d == 2'd3);
    assign ofm_data_out     = ofm_enable_write ? red : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_d          <= 1'b0;
            phase_d           <= 2'd0;
            acc               <= '0;
            ofm_address_write <= '0;
        end else begin
            rd_vld_d <= ifm_enable_read;
            phase_d  <= phase;
            if (state == IDLE && start_from_previous)
                ofm_address_write <= '0;
            else if (ofm_enable_write)
                ofm_address_write <= ofm_address_write + ADDR_OUT'(1);
            if (rd_vld_d)
                acc <= (phase_d == 2'd0) ? ext : acc_upd;
        end
    end
endmodule

// File: tb/tb_pool_a2_cu.sv
// Scoreboarded bench for pool_a2_cu: reference pooling model feeds an expected-write queue, a monitor checks writes.
module tb_pool_a2_cu;
    localparam int DW  = 32;
    localparam int IFM = 10;
    localparam int DEP = 2;
    localparam int OFM = IFM / 2;
    localparam int NRD = 4 * DEP * OFM * OFM;
    localparam int NWR = DEP * OFM * OFM;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_from_previous;
    logic        end_from_next;
    logic [31:0] ifm_data_in = '0;
    logic        end_to_previous;
    logic        ifm_sel_previous;
    logic        ifm_enable_read;
    logic [7:0]  ifm_address_read;
    logic        ofm_enable_write;
    logic [5:0]  ofm_address_write;
    logic [31:0] ofm_data_out;
    logic        ofm_sel_next;
    logic        start_to_next;
    logic        busy;

    always #5 clk = ~clk;

    pool_a2_cu #(.DATA_WIDTH(DW), .IFM_SIZE(IFM), .IFM_DEPTH(DEP)) dut (
        .clk(clk), .reset(reset),
        .start_from_previous(start_from_previous), .end_from_next(end_from_next),
        .ifm_data_in(ifm_data_in), .end_to_previous(end_to_previous),
        .ifm_sel_previous(ifm_sel_previous), .ifm_enable_read(ifm_enable_read),
        .ifm_address_read(ifm_address_read), .ofm_enable_write(ofm_enable_write),
        .ofm_address_write(ofm_address_write), .ofm_data_out(ofm_data_out),
        .ofm_sel_next(ofm_sel_next), .start_to_next(start_to_next), .busy(busy)
    );

    logic [31:0] mem [0:NRD-1];
    always @(posedge clk) if (ifm_enable_read) ifm_data_in <= mem[ifm_address_read];

    typedef struct { int addr; logic [31:0] val; } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int rd_count, wr_count, stn_count;
    int first_rd_cyc, last_rd_cyc, first_wr_cyc, stn_cyc;
    logic exp_sel_prev = 1'b0, exp_sel_next = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: pool the four pixels of window (d,r,c) straight from the map contents.
    function automatic logic [31:0] ref_pool(input int d, input int r, input int c);
        longint v [4];
        longint res;
        int b;
        b = d * IFM * IFM + 2 * r * IFM + 2 * c;
        v[0] = longint'($signed(mem[b]));
        v[1] = longint'($signed(mem[b + 1]));
        v[2] = longint'($signed(mem[b + IFM]));
        v[3] = longint'($signed(mem[b + IFM + 1]));
`ifdef POOL_A2_AVG_EN
        res = (v[0] + v[1] + v[2] + v[3]) >>> 2;
`else
        res = v[0];
        for (int i = 1; i < 4; i++) if (v[i] > res) res = v[i];
`endif
        return res[31:0];
    endfunction

    task automatic push_expected();
        int k = 0;
        for (int d = 0; d < DEP; d++)
            for (int r = 0; r < OFM; r++)
                for (int c = 0; c < OFM; c++) begin
                    exp_t e;
                    e.addr = k;
                    e.val  = ref_pool(d, r, c);
                    sb.push_back(e);
                    k++;
                end
    endtask

    always @(negedge clk) begin
        if (ifm_enable_read) begin
            if (rd_count == 0) begin
                first_rd_cyc = cyc;
                chk("first_rd_addr", ifm_address_read, 0);
            end
            last_rd_cyc = cyc;
            rd_count++;
        end
        if (ofm_enable_write) begin
            if (wr_count == 0) first_wr_cyc = cyc;
            wr_count++;
            chk("write_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", ofm_address_write, e.addr);
                chk("wr_data", $signed(ofm_data_out), $signed(e.val));
            end
        end
        if (start_to_next) begin
            stn_count++;
            stn_cyc = cyc;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        rd_count = 0; wr_count = 0; stn_count = 0;
        first_rd_cyc = -1; last_rd_cyc = -1; first_wr_cyc = -1; stn_cyc = -1;
    endtask

    task automatic start_buffer(output int t0);
        clear_stats();
        push_expected();
        step();
        start_from_previous = 1'b1;
        t0 = cyc;
        exp_sel_prev = ~exp_sel_prev;
        step();
        start_from_previous = 1'b0;
        chk("sel_prev_toggle", ifm_sel_previous, exp_sel_prev);
        chk("busy_run", busy, 1);
        chk("etp_run", end_to_previous, 0);
    endtask

    task automatic wait_stn(input string nm, input int budget);
        int n0 = stn_count;
        int k = 0;
        while (stn_count == n0 && k < budget) begin
            step();
            k++;
        end
        chk(nm, stn_count > n0, 1);
    endtask

    task automatic set_win(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
        mem[2 * k] = a; mem[2 * k + 1] = b; mem[2 * k + IFM] = c; mem[2 * k + IFM + 1] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int good;
        int wr_before;
        reset = 1'b1; start_from_previous = 1'b0; end_from_next = 1'b1;
        clear_stats();
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_etp", end_to_previous, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", ifm_enable_read, 0);
        chk("rst_sel_prev", ifm_sel_previous, 0);
        chk("rst_sel_next", ofm_sel_next, 0);
        chk("rst_stn", start_to_next, 0);

        // Buffer 1: pixel value equals its address, downstream always free.
        for (int i = 0; i < NRD; i++) mem[i] = i;
        start_buffer(t0);
        wait_stn("b1_stn_seen", 400);
        chk("b1_first_rd_cyc", first_rd_cyc - t0, 1);
        chk("b1_last_rd_cyc", last_rd_cyc - t0, NRD);
        chk("b1_rd_count", rd_count, NRD);
        chk("b1_first_wr_cyc", first_wr_cyc - t0, 5);
        chk("b1_wr_count", wr_count, NWR);
        chk("b1_stn_cyc", stn_cyc - t0, 203);
        chk("b1_sb_empty", sb.size(), 0);
        exp_sel_next = ~exp_sel_next;
        chk("b1_sel_next", ofm_sel_next, exp_sel_next);
        chk("b1_etp_idle", end_to_previous, 1);
        repeat (3) step();
        chk("b1_stn_single", stn_count, 1);

        // Buffer 2: random pixels plus corner windows; spurious start mid-RUN.
        for (int i = 0; i < NRD; i++) mem[i] = $urandom();
        set_win(0, 32'(-5), 32'(-1), 32'(-7), 32'(-3));
        set_win(1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        set_win(2, 32'd1, 32'd2, 32'd3, 32'd6);
        set_win(3, 32'(-1), 32'(-2), 32'(-3), 32'(-4));
        set_win(4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        start_buffer(t0);
        repeat (48) step();
        start_from_previous = 1'b1;
        step();
        start_from_previous = 1'b0;
        step();
        chk("b2_sel_prev_hold", ifm_sel_previous, exp_sel_prev);
        chk("b2_busy_hold", busy, 1);
        wait_stn("b2_stn_seen", 400);
        chk("b2_rd_count", rd_count, NRD);
        chk("b2_stn_cyc", stn_cyc - t0, 203);
        chk("b2_sb_empty", sb.size(), 0);
        exp_sel_next = ~exp_sel_next;
        chk("b2_sel_next", ofm_sel_next, exp_sel_next);

        // Buffer 3: downstream busy for 20 cycles after DRAIN.
        for (int i = 0; i < NRD; i++) mem[i] = $urandom();
        end_from_next = 1'b0;
        start_buffer(t0);
        good = 0;
        while (wr_count < NWR && good < 400) begin step(); good++; end
        chk("b3_drain_reached", wr_count, NWR);
        good = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy === 1'b1 && end_to_previous === 1'b0 && start_to_next === 1'b0) good++;
        end
        chk("b3_wait_hold_cycles", good, 20);
        chk("b3_no_stn_in_wait", stn_count, 0);
        end_from_next = 1'b1;
        wait_stn("b3_stn_seen", 10);
        exp_sel_next = ~exp_sel_next;
        chk("b3_sel_next", ofm_sel_next, exp_sel_next);
        chk("b3_etp_back", end_to_previous, 1);
        repeat (3) step();
        chk("b3_stn_single", stn_count, 1);

        // Buffer 4: reset in the middle of RUN, then a clean rerun.
        for (int i = 0; i < NRD; i++) mem[i] = $urandom();
        start_buffer(t0);
        repeat (99) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_rd_en", ifm_enable_read, 0);
        chk("mid_rst_rd_addr", ifm_address_read, 0);
        chk("mid_rst_wr_en", ofm_enable_write, 0);
        chk("mid_rst_wr_addr", ofm_address_write, 0);
        chk("mid_rst_data", ofm_data_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_etp", end_to_previous, 1);
        chk("mid_rst_sel_prev", ifm_sel_previous, 0);
        chk("mid_rst_sel_next", ofm_sel_next, 0);
        chk("mid_rst_stn", start_to_next, 0);
        exp_sel_prev = 1'b0;
        exp_sel_next = 1'b0;
        sb.delete();
        repeat (2) step();
        reset = 1'b0;
        wr_before = wr_count;
        repeat (250) step();
        chk("post_rst_no_stn", stn_count, 0);
        chk("post_rst_no_wr", wr_count, wr_before);

        for (int i = 0; i < NRD; i++) mem[i] = $urandom();
        start_buffer(t0);
        wait_stn("b5_stn_seen", 400);
        chk("b5_first_rd_cyc", first_rd_cyc - t0, 1);
        chk("b5_rd_count", rd_count, NRD);
        chk("b5_sb_empty", sb.size(), 0);
        chk("b5_stn_cyc", stn_cyc - t0, 203);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
